// File: rtl/bcd_run_ctrl_if.sv
// bcd_run_ctrl_if: buttons, 1 Hz input and counter controls of the run controller.
interface bcd_run_ctrl_if;
  logic       btn_start_stop;
  logic       btn_clear;
  logic       clk_1Hz;
  logic       counter_max;
  logic       cnt_en;
  logic       cnt_clr;
  logic       gen_rst;
  logic       running;
  logic [1:0] state;
  modport master (
    output btn_start_stop, btn_clear, clk_1Hz, counter_max,
    input  cnt_en, cnt_clr, gen_rst, running, state
  );
  modport slave (
    input  btn_start_stop, btn_clear, clk_1Hz, counter_max,
    output cnt_en, cnt_clr, gen_rst, running, state
  );
endinterface

// File: rtl/bcd_run_ctrl.sv
// bcd_run_ctrl: debounced run/pause/clear FSM driving the seconds BCD counter.
module bcd_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit STOP_AT_MAX     = 1'b1
) (
  input logic           clk_50MHz,
  input logic           reset,
  bcd_run_ctrl_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  logic [1:0]    raw, s1_q, s2_q, lvl_q, arm_q, prs_q, vld_q;
  logic [CW-1:0] cnt_q [2];
  logic [2:0]    tk_q;
  logic          tick, en_q, clr_q, grst_q, run_q;
  state_t        st_q;
  assign raw  = {bus.btn_clear, bus.btn_start_stop};
  assign tick = tk_q[2] & ~tk_q[1];
  // A button only arms once it is seen released after reset, so one held through reset gives no event.
  always_ff @(posedge clk_50MHz or posedge reset)
    if (reset) begin
      s1_q  <= '0;
      s2_q  <= '0;
      lvl_q <= '0;
      arm_q <= '0;
      prs_q <= '0;
      vld_q <= '0;
      cnt_q <= '{default: '0};
      tk_q  <= '0;
    end else begin
      s1_q  <= raw;
      s2_q  <= s1_q;
      vld_q <= {vld_q[0], 1'b1};
      arm_q <= arm_q | ({2{vld_q[1]}} & ~s2_q);
      tk_q  <= {tk_q[1:0], bus.clk_1Hz};
      for (int i = 0; i < 2; i++) begin
        prs_q[i] <= 1'b0;
        if (s2_q[i] == lvl_q[i])
          cnt_q[i] <= '0;
        else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt_q[i] <= '0;
          lvl_q[i] <= s2_q[i];
          prs_q[i] <= s2_q[i] & arm_q[i];
        end else
          cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  always_ff @(posedge clk_50MHz or posedge reset)
    if (reset) begin
      st_q   <= IDLE;
      en_q   <= 1'b0;
      clr_q  <= 1'b0;
      grst_q <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      en_q   <= 1'b0;
      clr_q  <= 1'b0;
      grst_q <= 1'b0;
      if (prs_q[1]) begin
        st_q  <= IDLE;
        clr_q <= 1'b1;
        run_q <= 1'b0;
      end else if (prs_q[0]) begin
        st_q   <= (st_q == RUN) ? PAUSE : RUN;
        run_q  <= st_q != RUN;
        grst_q <= st_q != RUN;
        clr_q  <= st_q == DONE;
      end else if (tick && st_q == RUN && bus.counter_max && STOP_AT_MAX) begin
        st_q  <= DONE;
        run_q <= 1'b0;
      end else if (tick && st_q == RUN)
        en_q <= 1'b1;
    end
  assign bus.cnt_en  = en_q;
  assign bus.cnt_clr = clr_q;
  assign bus.gen_rst = grst_q;
  assign bus.running = run_q;
  assign bus.state   = st_q;
endmodule

// File: tb/tb_bcd_run_ctrl.sv
// tb_bcd_run_ctrl: directed and random stimulus on both STOP_AT_MAX variants against a reference model.
module tb_bcd_run_ctrl;
  localparam int D = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic b_ss = 1'b0, b_cl = 1'b0, c1 = 1'b0, cmax = 1'b0;
  bcd_run_ctrl_if if_s();
  bcd_run_ctrl_if if_w();
  assign if_s.btn_start_stop = b_ss;
  assign if_s.btn_clear      = b_cl;
  assign if_s.clk_1Hz        = c1;
  assign if_s.counter_max    = cmax;
  assign if_w.btn_start_stop = b_ss;
  assign if_w.btn_clear      = b_cl;
  assign if_w.clk_1Hz        = c1;
  assign if_w.counter_max    = cmax;
  bcd_run_ctrl #(.DEBOUNCE_CYCLES(D), .STOP_AT_MAX(1'b1)) u_s (.clk_50MHz(clk), .reset(rst), .bus(if_s.slave));
  bcd_run_ctrl #(.DEBOUNCE_CYCLES(D), .STOP_AT_MAX(1'b0)) u_w (.clk_50MHz(clk), .reset(rst), .bus(if_w.slave));
  always #10 clk = ~clk;
  int checks = 0, errors = 0;
  bit raw [3][8192];
  int e;
  bit lvl [2], arm [2], prs [2];
  int mst [2];
  bit men [2], mclr [2], mgr [2];
  bit stop [2] = '{1'b1, 1'b0};
  int n_en [2], n_gr [2], n_clr [2], n_both;
  // Synchronized button level seen by the debouncer at edge k: the raw sample two edges earlier.
  function automatic bit din(int b, int k);
    return (k >= 2) ? raw[b][k-2] : 1'b0;
  endfunction
  task automatic model_reset();
    e = 0;
    for (int d = 0; d < 2; d++) begin
      lvl[d] = 0; arm[d] = 0; prs[d] = 0;
      mst[d] = 0; men[d] = 0; mclr[d] = 0; mgr[d] = 0;
    end
  endtask
  task automatic model_edge();
    bit ps, pc, tk, fl;
    ps = prs[0];
    pc = prs[1];
    raw[0][e] = b_ss;
    raw[1][e] = b_cl;
    raw[2][e] = c1;
    tk = (e >= 3) ? (raw[2][e-3] && !raw[2][e-2]) : 1'b0;
    for (int b = 0; b < 2; b++) begin
      fl = (e >= D - 1);
      if (fl)
        for (int k = e - D + 1; k <= e; k++)
          if (din(b, k) == lvl[b]) fl = 0;
      prs[b] = fl && !lvl[b] && arm[b];
      if (fl) lvl[b] = !lvl[b];
      if (e >= 2 && !din(b, e)) arm[b] = 1;
    end
    for (int d = 0; d < 2; d++) begin
      men[d] = 0; mclr[d] = 0; mgr[d] = 0;
      if (pc) begin
        mst[d] = 0; mclr[d] = 1;
      end else if (ps) begin
        mgr[d]  = (mst[d] != 1);
        mclr[d] = (mst[d] == 3);
        mst[d]  = (mst[d] == 1) ? 2 : 1;
      end else if (tk && mst[d] == 1) begin
        if (cmax && stop[d]) mst[d] = 3;
        else men[d] = 1;
      end
    end
    e++;
  endtask
  task automatic check(string tag);
    logic [5:0] obs, exp;
    for (int d = 0; d < 2; d++) begin
      obs = d ? {if_w.state, if_w.running, if_w.gen_rst, if_w.cnt_clr, if_w.cnt_en}
              : {if_s.state, if_s.running, if_s.gen_rst, if_s.cnt_clr, if_s.cnt_en};
      exp = {2'(mst[d]), mst[d] == 1, mgr[d], mclr[d], men[d]};
      checks++;
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s dut%0d observed=%b expected=%b", tag, d, obs, exp);
      end
      n_en[d]  += int'(obs[0]);
      n_clr[d] += int'(obs[1]);
      n_gr[d]  += int'(obs[2]);
    end
    n_both += int'(if_s.cnt_clr && if_s.gen_rst);
  endtask
  task automatic expect_eq(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step(string tag, int n = 1);
    repeat (n) begin
      @(posedge clk);
      if (!rst) model_edge();
      @(negedge clk);
      check(tag);
    end
  endtask
  task automatic clr_counts();
    for (int d = 0; d < 2; d++) begin
      n_en[d] = 0; n_gr[d] = 0; n_clr[d] = 0;
    end
    n_both = 0;
  endtask
  task automatic press_ss(string tag);
    b_ss = 1'b1; step(tag, 10);
    b_ss = 1'b0; step(tag, 10);
  endtask
  task automatic fall(string tag);
    c1 = 1'b1; step(tag, 6);
    c1 = 1'b0; step(tag, 6);
  endtask
  initial begin
    model_reset();
    step("reset", 2);
    expect_eq("reset_outputs", {if_s.state, if_s.running, if_s.gen_rst, if_s.cnt_clr, if_s.cnt_en}, 0);
    rst = 1'b0;
    step("idle", 3);
    clr_counts();
    press_ss("start");
    expect_eq("start_state", if_s.state, 1);
    expect_eq("start_running", if_s.running, 1);
    expect_eq("start_gen_rst", n_gr[0], 1);
    clr_counts();
    repeat (3) fall("count");
    expect_eq("count_en_stop", n_en[0], 3);
    expect_eq("count_en_wrap", n_en[1], 3);
    press_ss("pause");
    expect_eq("pause_state", if_s.state, 2);
    clr_counts();
    repeat (2) fall("paused");
    expect_eq("pause_no_en", n_en[0], 0);
    press_ss("resume");
    expect_eq("resume_state", if_s.state, 1);
    expect_eq("resume_gen_rst", n_gr[0], 1);
    cmax = 1'b1;
    clr_counts();
    fall("max");
    expect_eq("max_done_state", if_s.state, 3);
    expect_eq("max_no_en", n_en[0], 0);
    expect_eq("wrap_state", if_w.state, 1);
    expect_eq("wrap_en", n_en[1], 1);
    cmax = 1'b0;
    clr_counts();
    press_ss("restart");
    expect_eq("restart_state", if_s.state, 1);
    expect_eq("restart_clr_gr", n_both, 1);
    b_cl = 1'b1; step("clear", 10);
    b_cl = 1'b0; step("clear", 10);
    expect_eq("clear_state", if_s.state, 0);
    clr_counts();
    for (int i = 0; i < 10; i++) begin
      b_ss = ~b_ss; step("bounce", 2);
    end
    b_ss = 1'b1; step("bounce", 10);
    b_ss = 1'b0; step("bounce", 10);
    expect_eq("bounce_one_event", n_gr[0], 1);
    expect_eq("bounce_state", if_s.state, 1);
    c1 = 1'b1; step("simul", 8);
    b_ss = 1'b1; b_cl = 1'b1; step("simul", 4);
    c1 = 1'b0; step("simul", 3);
    expect_eq("simul_s", {if_s.state, if_s.cnt_clr, if_s.cnt_en, if_s.gen_rst}, 5'b00100);
    expect_eq("simul_w", {if_w.state, if_w.cnt_clr, if_w.cnt_en, if_w.gen_rst}, 5'b00100);
    b_ss = 1'b0; b_cl = 1'b0; step("simul", 10);
    press_ss("rerun");
    expect_eq("rerun_state", if_s.state, 1);
    b_ss = 1'b1; step("db_prog", 3);
    rst = 1'b1;
    #1;
    model_reset();
    expect_eq("async_rst", {if_s.state, if_s.running, if_s.gen_rst, if_s.cnt_clr, if_s.cnt_en}, 0);
    step("in_rst", 3);
    rst = 1'b0;
    clr_counts();
    step("held", 20);
    expect_eq("held_state", if_s.state, 0);
    expect_eq("held_no_event", n_gr[0], 0);
    b_ss = 1'b0; step("release", 10);
    press_ss("repress");
    expect_eq("repress_state", if_s.state, 1);
    repeat (800) begin
      if ($urandom_range(0, 9) == 0) b_ss = ~b_ss;
      if ($urandom_range(0, 19) == 0) b_cl = ~b_cl;
      if ($urandom_range(0, 5) == 0) c1 = ~c1;
      cmax = ($urandom_range(0, 3) == 0);
      step("random");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_run_ctrl.md
# bcd_run_ctrl

Run/pause/clear controller for the seconds BCD counter chain. It debounces two push-buttons and brings the 1 Hz generator output into the clk_50MHz domain as a single-cycle tick. A four-state FSM then issues one-cycle count-enable and clear pulses to the BCD counter. It also re-phases the 1 Hz generator on every start so the first count lands exactly 1 s after the start press.

## Interface
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a button level (20 ms at 50 MHz); minimum 2.
- STOP_AT_MAX, 1: 1 = halt in DONE when the counter is at its maximum; 0 = keep counting and let the counter wrap.

Ports (reset reset, asynchronous, active-high; clock clk_50MHz):
- clk_50MHz  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears every register.
- btn_start_stop  in  1  raw, asynchronous, bouncing push-button; high = pressed.
- btn_clear  in  1  raw, asynchronous, bouncing push-button; high = pressed.
- clk_1Hz  in  1  output of the 1 Hz generator; asynchronous to clk_50MHz for CDC purposes.
- counter_max  in  1  from the BCD counter; high while the count equals its maximum value.
- cnt_en  out  1  one-cycle pulse; the counter increments by one.
- cnt_clr  out  1  one-cycle pulse; synchronous clear of the counter.
- gen_rst  out  1  one-cycle pulse wired to the 1 Hz generator reset.
- running  out  1  high in RUN.
- state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.

## Operation
- **Button conditioning (per button, identical logic)**
  - Two-FF synchronizer feeds a debounce counter.
  - The debounced level takes the synchronized value after it has differed from the current debounced level for DEBOUNCE_CYCLES consecutive cycles.
  - Any cycle where the synchronized value matches the debounced level resets the counter to 0.
  - A press event is a one-cycle pulse in the cycle the debounced level goes 0→1. Releases generate no event.
- **Tick extraction**
  - clk_1Hz goes through a two-FF synchronizer plus one history FF.
  - tick = history & ~sync2, i.e. the falling edge of clk_1Hz.
  - After the generator is reset, its output first rises 25,000,000 cycles later and first falls 50,000,000 cycles later. The falling edge is therefore used, so that exactly one tick occurs per second.
- **FSM, evaluated with priority reset > clear event > start_stop event > tick**
  - Any state + clear event → IDLE; cnt_clr pulses.
  - IDLE + start_stop → RUN; gen_rst pulses.
  - RUN + start_stop → PAUSE.
  - PAUSE + start_stop → RUN; gen_rst pulses, and the sub-second phase is discarded.
  - DONE + start_stop → RUN; cnt_clr and gen_rst pulse together.
  - RUN + tick, counter_max=0 → cnt_en pulses.
  - RUN + tick, counter_max=1, STOP_AT_MAX=1 → DONE; no cnt_en.
  - RUN + tick, counter_max=1, STOP_AT_MAX=0 → cnt_en pulses (the counter wraps); stay in RUN.
  - Ticks in IDLE, PAUSE and DONE are ignored.
- **Simultaneous events**
  - clear and start_stop in the same cycle: clear wins and start_stop is dropped.
  - A clear or start_stop event in the same cycle as a tick: the tick is dropped.
- **Reset values**
  - state=IDLE, all pulses 0, running=0.
  - All synchronizer, history and debounce registers 0; debounced levels 0.
  - A button held through reset release produces no event until it has been released and pressed again.

## Timing
- All outputs are registered.
- cnt_clr, gen_rst and cnt_en are each high for exactly one cycle per event.
- Tick latency:
  - clk_1Hz falls before edge E0; sync1 captures 0 at E0 and sync2 at E1.
  - tick is combinationally high between E1 and E2.
  - cnt_en is high in the cycle following E2; it falls at E3.
- Button latency: from the first synchronized-pressed cycle to the event pulse is DEBOUNCE_CYCLES cycles. The FSM output reacts one cycle after the event.
- gen_rst is asserted in the same cycle as the RUN entry in `state`. The first cnt_en follows roughly 50,000,000 cycles plus synchronizer latency later.
- Bounce shorter than DEBOUNCE_CYCLES produces no event and no state change.
- reset asserted mid-operation forces reset values immediately, with no pulse emitted.

## Test plan
Run with DEBOUNCE_CYCLES=4 and drive clk_1Hz directly from the bench.
- **Start and count:** reset, clean start_stop press held for 10 cycles → gen_rst pulses once, state=1, running=1. Three falling edges on clk_1Hz → exactly three single-cycle cnt_en pulses, each 3 edges after its clk_1Hz fall.
- **Bounce rejection:** start_stop toggled 0/1 every 2 cycles for 20 cycles, then held high → exactly one event; state IDLE→RUN once.
- **Pause:** RUN, press start_stop → state=2. Two clk_1Hz falls → no cnt_en. Press again → state=1 with gen_rst pulse.
- **Terminal count:** STOP_AT_MAX=1, RUN, counter_max=1, clk_1Hz fall → state=3, no cnt_en. Press start_stop → cnt_clr and gen_rst in the same cycle, state=1. Repeat with STOP_AT_MAX=0 → cnt_en pulses and state stays 1.
- **Simultaneous events:** clear and start_stop debounced in the same cycle while RUN, aligned with a tick → state=0, cnt_clr=1, cnt_en=0, gen_rst=0.
- **Reset mid-run:** assert reset while running with a debounce in progress → all outputs 0 and state=0 at once. start_stop still held at reset release → no event until it is released and re-pressed.
